cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle instruction sequencer for the 32-bit processor core. Fetches an instruction over a req/ack instruction-memory handshake and holds it in the instruction register (IR) that feeds the combinational decoder. It then steps decode, execute, memory and writeback, gates the decoder's write strobes, and updates the PC. It stalls on memory acknowledges and on multi-cycle mul/div completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 1, PC increment for sequential flow (word addressed)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  fetched instruction word
imem_ack  in  1  fetch data valid
ir  out  32  instruction register, drives decoder
pc  out  32  address of instruction in ir
dec_jump  in  1  decoder jump flag
dec_pc_load_imm  in  1  decoder: jump target is dec_imm_val
dec_imm_val  in  32  decoder immediate / branch target
dec_wr  in  1  decoder register-write enable
dec_memrd  in  1  decoder load flag
dec_memwr  in  1  decoder store flag
reg_target  in  32  register-file src1 read data (return target)
alu_start  out  1  one-cycle start pulse for mul/div unit
alu_done  in  1  mul/div result valid
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ack  in  1  data memory complete
rf_we  out  1  gated register-file write strobe
instr_retired  out  1  one-cycle pulse per completed instruction
state_o  out  3  current FSM state encoding

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, ir=0, all strobes 0, latched branch regs 0.
- State encodings: FETCH=0, DECODE=1, EXEC=2, EXEC_WAIT=3, MEM=4, WB=5.
- FETCH
  - imem_req=1 and imem_addr=pc, held until imem_ack.
  - On ack: ir<=imem_rdata, go to DECODE.
  - Zero-wait ack (same cycle as first req) is legal.
- DECODE: single cycle; decoder and register file settle on ir. Go to EXEC.
- EXEC
  - Multi-cycle opcode (ir[31:26] in {7,8,23,24}): alu_start=1 for this cycle only, go to EXEC_WAIT.
  - Otherwise: latch jump_q=dec_jump, pli_q=dec_pc_load_imm, imm_q=dec_imm_val, tgt_q=reg_target, wr_q=dec_wr. Next state is MEM if dec_memrd|dec_memwr, else WB.
- EXEC_WAIT
  - Hold until alu_done=1, then perform the same latch and next-state selection as EXEC.
  - alu_done=1 on the cycle after alu_start is legal.
- MEM
  - dmem_req=1, dmem_we=dec_memwr, held until dmem_ack.
  - dec_memrd and dec_memwr both 1 is treated as a store.
  - On dmem_ack, go to WB.
- WB (single cycle)
  - rf_we=wr_q; instr_retired=1.
  - PC update:
    - jump_q&pli_q: pc<=imm_q
    - jump_q&!pli_q: pc<=tgt_q
    - otherwise: pc<=pc+PC_STEP, 32-bit modulo (0xFFFF_FFFF+1 -> 0).
  - Next state FETCH.
- Conditional branches are resolved from flags sampled in EXEC/EXEC_WAIT only; later flag changes are ignored.
- Any imem_ack, dmem_ack or alu_done arriving outside its wait state is ignored.
- rf_we, alu_start, instr_retired are never asserted outside the states above.
- Reset asserted mid-instruction: immediate abort, no pending write strobe, restart at RESET_PC.
- Minimum latency: 4 cycles per non-memory single-cycle instruction (FETCH, DECODE, EXEC, WB) with zero-wait ack.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on every instr_retired.
  - stall_cnt increments on each cycle spent in FETCH without imem_ack, in MEM without dmem_ack, or in EXEC_WAIT without alu_done.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait acks, ADD (opcode 1, dec_wr=1) -> imem_addr=0x100; rf_we pulse in cycle 4; pc=0x101; instr_retired once.
- JMP, dec_jump=1, dec_pc_load_imm=1, dec_imm_val=0x40 -> next imem_addr=0x40, rf_we=0.
- RET, dec_jump=1, dec_pc_load_imm=0, reg_target=0x2A -> next fetch at 0x2A.
- MUL (opcode 7), alu_done 5 cycles after alu_start -> single alu_start pulse; state_o=3 for 5 cycles; WB follows done; total 9 cycles.
- STR (dec_memwr=1), dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, rf_we=0, pc+1.
- rst_n dropped during MEM with pc=0x55 -> immediately state_o=0, pc=RESET_PC, dmem_req=0; no instr_retired pulse.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory, data-memory and mul/div handshakes between the sequencer and the core.
interface cpu_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        alu_start;
  logic        alu_done;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, alu_start,
    input  imem_rdata, imem_ack, dmem_ack, alu_done
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, alu_start,
    output imem_rdata, imem_ack, dmem_ack, alu_done
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/writeback sequencer with IR, PC and gated write strobes.
// Define SEQ_PERF_CNT_EN to add the retired_cnt/stall_cnt performance counters.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  cpu_sequencer_if.master bus,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic        dec_jump,
  input  logic        dec_pc_load_imm,
  input  logic [31:0] dec_imm_val,
  input  logic        dec_wr,
  input  logic        dec_memrd,
  input  logic        dec_memwr,
  input  logic [31:0] reg_target,
  output logic        rf_we,
  output logic        instr_retired,
  output logic [2:0]  state_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC      = 3'd2,
    EXEC_WAIT = 3'd3,
    MEM       = 3'd4,
    WB        = 3'd5
  } state_t;
  state_t      state_q;
  logic [31:0] pc_q, ir_q, imm_q, tgt_q;
  logic        jump_q, pli_q, wr_q;
  logic        mul_op, resolve;
  assign mul_op  = ir_q[31:26] inside {6'd7, 6'd8, 6'd23, 6'd24};
  // Branch flags are captured exactly once, when the execute phase completes.
  assign resolve = (state_q == EXEC && !mul_op) || (state_q == EXEC_WAIT && bus.alu_done);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      imm_q   <= '0;
      tgt_q   <= '0;
      jump_q  <= 1'b0;
      pli_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH:
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            state_q <= DECODE;
          end
        DECODE: state_q <= EXEC;
        EXEC, EXEC_WAIT:
          if (resolve) begin
            jump_q  <= dec_jump;
            pli_q   <= dec_pc_load_imm;
            imm_q   <= dec_imm_val;
            tgt_q   <= reg_target;
            wr_q    <= dec_wr;
            state_q <= (dec_memrd || dec_memwr) ? MEM : WB;
          end else
            state_q <= EXEC_WAIT;
        MEM: if (bus.dmem_ack) state_q <= WB;
        WB: begin
          pc_q    <= jump_q ? (pli_q ? imm_q : tgt_q) : pc_q + PC_STEP;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  assign bus.imem_req   = state_q == FETCH;
  assign bus.imem_addr  = pc_q;
  assign bus.alu_start  = state_q == EXEC && mul_op;
  assign bus.dmem_req   = state_q == MEM;
  assign bus.dmem_we    = state_q == MEM && dec_memwr;
  assign rf_we          = state_q == WB && wr_q;
  assign instr_retired  = state_q == WB;
  assign state_o        = state_q;
  assign pc             = pc_q;
  assign ir             = ir_q;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;
  logic        stall;
  assign stall = (state_q == FETCH && !bus.imem_ack) || (state_q == MEM && !bus.dmem_ack) ||
                 (state_q == EXEC_WAIT && !bus.alu_done);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_q + 32'(instr_retired);
      stall_q   <= stall_q + 32'(stall);
    end
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: per-instruction timeline model of the sequencer, randomized plans plus directed pins.
module tb_cpu_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int F = 0, D = 1, E = 2, W = 3, M = 4, B = 5;
  typedef struct {
    logic [5:0]  op;
    bit          jump, pli, wr, rd, st;
    logic [31:0] imm, tgt;
    int          fw, aw, mw;
  } plan_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cpu_sequencer_if bus();
  logic [31:0] ir, pc, dec_imm_val, reg_target;
  logic        dec_jump, dec_pc_load_imm, dec_wr, dec_memrd, dec_memwr, rf_we, instr_retired;
  logic [2:0]  state_o;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif
  cpu_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ir(ir), .pc(pc),
    .dec_jump(dec_jump), .dec_pc_load_imm(dec_pc_load_imm), .dec_imm_val(dec_imm_val),
    .dec_wr(dec_wr), .dec_memrd(dec_memrd), .dec_memwr(dec_memwr), .reg_target(reg_target),
    .rf_we(rf_we), .instr_retired(instr_retired), .state_o(state_o)
`ifdef SEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_ir, m_ret, m_stall, first_addr;
  plan_t cp;
  bit    cmul;
  int    ncyc, nreq, nwe, nrf, nret, nstart, nwait, rf_cyc;
  logic [5:0] mops [4] = '{6'd7, 6'd8, 6'd23, 6'd24};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic compare(input int st);
    chk("state", 32'(state_o), st);
    chkb("imem_req", bus.imem_req, st == F);
    if (st == F) chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("ir", ir, m_ir);
    chkb("alu_start", bus.alu_start, st == E && cmul);
    chkb("dmem_req", bus.dmem_req, st == M);
    chkb("dmem_we", bus.dmem_we, st == M && cp.st);
    chkb("rf_we", rf_we, st == B && cp.wr);
    chkb("instr_retired", instr_retired, st == B);
`ifdef SEQ_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    ncyc++;
    if (bus.dmem_req) nreq++;
    if (bus.dmem_we) nwe++;
    if (rf_we) begin nrf++; rf_cyc = ncyc; end
    if (instr_retired) nret++;
    if (bus.alu_start) nstart++;
    if (state_o == 3'd3) nwait++;
  endtask
  task automatic cycle(input int st, input bit stall);
    #1 compare(st);
    if (stall) m_stall++;
    @(negedge clk);
  endtask
  task automatic noise();
    bus.imem_ack   = 1'($urandom);
    bus.dmem_ack   = 1'($urandom);
    bus.alu_done   = 1'($urandom);
    bus.imem_rdata = $urandom;
  endtask
  task automatic dec_rand();
    dec_jump = 1'($urandom); dec_pc_load_imm = 1'($urandom); dec_wr = 1'($urandom);
    dec_memrd = 1'($urandom); dec_memwr = 1'($urandom);
    dec_imm_val = $urandom; reg_target = $urandom;
  endtask
  task automatic dec_plan();
    dec_jump = cp.jump; dec_pc_load_imm = cp.pli; dec_wr = cp.wr;
    dec_memrd = cp.rd; dec_memwr = cp.st;
    dec_imm_val = cp.imm; reg_target = cp.tgt;
  endtask
  function automatic plan_t mk(input logic [5:0] op, input bit j, l, input logic [31:0] imm, tgt,
                               input bit wr, rd, st, input int fw, aw, mw);
    plan_t p;
    p.op = op; p.jump = j; p.pli = l; p.imm = imm; p.tgt = tgt;
    p.wr = wr; p.rd = rd; p.st = st; p.fw = fw; p.aw = aw; p.mw = mw;
    return p;
  endfunction
  // Walks one instruction through its phases; rst_at >= 0 drops reset on that MEM cycle.
  task automatic run(input plan_t p, input int rst_at);
    logic [31:0] word;
    cp = p;
    cmul = p.op inside {6'd7, 6'd8, 6'd23, 6'd24};
    word = {p.op, 26'($urandom)};
    ncyc = 0; nreq = 0; nwe = 0; nrf = 0; nret = 0; nstart = 0; nwait = 0; rf_cyc = 0;
    first_addr = bus.imem_addr;
    for (int j = 0; j <= p.fw; j++) begin
      noise(); dec_rand();
      bus.imem_ack = j == p.fw;
      if (j == p.fw) bus.imem_rdata = word;
      cycle(F, j != p.fw);
    end
    m_ir = word;
    noise(); dec_rand();
    cycle(D, 1'b0);
    noise();
    if (cmul) dec_rand(); else dec_plan();
    cycle(E, 1'b0);
    if (cmul)
      for (int j = 0; j < p.aw; j++) begin
        noise();
        if (j == p.aw - 1) dec_plan(); else dec_rand();
        bus.alu_done = j == p.aw - 1;
        cycle(W, j != p.aw - 1);
      end
    if (p.rd || p.st)
      for (int j = 0; j <= p.mw; j++) begin
        noise(); dec_plan();
        bus.dmem_ack = j == p.mw;
        if (j == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_state", 32'(state_o), 32'd0);
          chk("rst_pc", pc, RPC);
          chkb("rst_dmem_req", bus.dmem_req, 1'b0);
          chkb("rst_retired", instr_retired, 1'b0);
          chkb("rst_rf_we", rf_we, 1'b0);
          m_pc = RPC; m_ir = '0; m_ret = '0; m_stall = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        cycle(M, j != p.mw);
      end
    noise(); dec_rand();
    cycle(B, 1'b0);
    m_ret++;
    m_pc = p.jump ? (p.pli ? p.imm : p.tgt) : m_pc + 32'd1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    plan_t p;
    int ra;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.alu_done = 1'b0; bus.imem_rdata = '0;
    dec_jump = 1'b0; dec_pc_load_imm = 1'b0; dec_wr = 1'b0; dec_memrd = 1'b0; dec_memwr = 1'b0;
    dec_imm_val = '0; reg_target = '0;
    m_pc = RPC; m_ir = '0; m_ret = '0; m_stall = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_pc", pc, 32'h100);
    chk("reset_ir", ir, 32'd0);
    chkb("reset_rf_we", rf_we, 1'b0);
    chkb("reset_retired", instr_retired, 1'b0);
    chkb("reset_alu_start", bus.alu_start, 1'b0);
    chkb("reset_dmem_req", bus.dmem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(6'd1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), -1);
    chk("add_first_addr", first_addr, 32'h100);
    chk("add_cycles", ncyc, 4);
    chk("add_rf_cycle", rf_cyc, 4);
    chk("add_retired", nret, 1);
    chk("add_pc", pc, 32'h101);
    run(mk(6'd2, 1, 1, 32'h40, 32'h999, 0, 0, 0, 0, 1, 0), -1);
    chk("jmp_pc", pc, 32'h40);
    chk("jmp_rf", nrf, 0);
    run(mk(6'd3, 1, 0, 32'h77, 32'h2A, 0, 0, 0, 2, 1, 0), -1);
    chk("ret_first_addr", first_addr, 32'h40);
    chk("ret_pc", pc, 32'h2A);
    run(mk(6'd7, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0), -1);
    chk("mul_first_addr", first_addr, 32'h2A);
    chk("mul_cycles", ncyc, 9);
    chk("mul_starts", nstart, 1);
    chk("mul_wait", nwait, 5);
    chk("mul_rf_cycle", rf_cyc, 9);
    chk("mul_pc", pc, 32'h2B);
    run(mk(6'd4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3), -1);
    chk("str_req_cycles", nreq, 4);
    chk("str_we_cycles", nwe, 4);
    chk("str_rf", nrf, 0);
    chk("str_pc", pc, 32'h2C);
    run(mk(6'd2, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0), -1);
    run(mk(6'd1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), -1);
    chk("wrap_pc", pc, 32'h0);
    run(mk(6'd2, 1, 1, 32'h55, 0, 0, 0, 0, 0, 1, 0), -1);
    run(mk(6'd5, 0, 0, 0, 0, 1, 1, 0, 1, 1, 4), 2);
    chk("abort_pc", pc, 32'h100);
    chk("abort_retired", nret, 0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) p.op = mops[$urandom_range(0, 3)];
      else begin
        p.op = 6'($urandom);
        while (p.op inside {6'd7, 6'd8, 6'd23, 6'd24}) p.op = 6'($urandom);
      end
      p.jump = $urandom_range(0, 3) == 0; p.pli = 1'($urandom);
      p.imm = $urandom; p.tgt = $urandom; p.wr = 1'($urandom);
      p.rd = $urandom_range(0, 2) == 0; p.st = $urandom_range(0, 2) == 0;
      p.fw = $urandom_range(0, 3); p.aw = $urandom_range(1, 4); p.mw = $urandom_range(0, 3);
      ra = ((p.rd || p.st) && $urandom_range(0, 19) == 0) ? int'($urandom_range(0, p.mw)) : -1;
      run(p, ra);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
